stdp_synapse: RTL and testbench
===============================

# stdp_synapse

Plastic synapse between the presynaptic and postsynaptic `lif` neurons in the STDP demo top level. It timestamps pre- and post-synaptic spikes, applies a pair-based STDP rule to an 8-bit saturating weight, and drives the postsynaptic neuron's input current as weight × pre_spike. It consumes the presynaptic `lif` spike and feeds the postsynaptic `lif` current input. It also takes the postsynaptic spike back as the learning signal.

## Interface
- `W_INIT`, 1: weight value loaded at reset.
- `W_MAX`, 255: upper saturation bound of the weight.
- `WINDOW`, 16: STDP window in cycles; a power of two, at least 4.
- `DELTA_MAX`, 16: weight step for the closest spike pair.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pre_spike`  in  1  presynaptic spike, one-cycle pulse.
- `post_spike`  in  1  postsynaptic spike, one-cycle pulse.
- `learn_en`  in  1  1 = weight updates allowed; 0 = weight frozen.
- `weight`  out  8  current synaptic weight, registered.
- `syn_current`  out  8  current into the postsynaptic `lif`, registered.
- `update_w_flag`  out  1  one-cycle pulse when the weight was just updated.
- `ltp_flag`  out  1  qualifies `update_w_flag`: 1 = potentiation, 0 = depression.
- `time_diff`  out  5  dt of the last applied update; held between updates.

## Operation
- **Spike timers.** Two timers, `t_pre` and `t_post`, each 5 bits and saturating at WINDOW.
  - A timer loads 0 on any edge where its own spike is sampled high.
  - Otherwise it increments by 1, saturating at WINDOW.
- **dt definition.** dt is the opposite timer's value *before* the edge. A spike one cycle earlier gives dt=0.
- **LTP.** Triggered when `post_spike`=1, `pre_spike`=0, and `t_pre` < WINDOW. dt = `t_pre`.
- **LTD.** Triggered when `pre_spike`=1, `post_spike`=0, and `t_post` < WINDOW. dt = `t_post`.
- **Step size.** delta = DELTA_MAX >> (dt / (WINDOW/4)). With the defaults:
  - dt 0–3 → 16
  - dt 4–7 → 8
  - dt 8–11 → 4
  - dt 12–15 → 2
- **Simultaneous pre and post.** No update. Both timers clear.
- **learn_en=0.** No update is queued. Timers and `syn_current` keep operating.
- **Update pipeline.** Two stages.
  - Stage 1 registers {valid, ltp, delta, dt}. It is written every cycle, with valid=0 when nothing triggers.
  - Stage 2 applies the update: weight = min(weight+delta, W_MAX) for LTP, max(weight−delta, 0) for LTD.
  - Arithmetic is done at 9 bits, then clamped.
  - A new update can be accepted every cycle, so there is no stall.
- **syn_current.** Registered each edge as `pre_spike` ? `weight` : 0. It uses the weight register value before that edge's update.

## Timing
- **Reset values.** `weight`=W_INIT, `syn_current`=0, `update_w_flag`=0, `ltp_flag`=0, `time_diff`=0. Both timers = WINDOW, so there is no spike history. Stage 1 valid=0.
- **Reset mid-operation.** The asynchronous reset drops any pending update. No flag pulse follows reset release.
- **Update latency.** A spike sampled at edge n is registered in stage 1. At edge n+1:
  - `weight`, `ltp_flag` and `time_diff` take their new values.
  - `update_w_flag`=1 for exactly the cycle after edge n+1.
- **Current latency.** A pre spike sampled at edge n gives `syn_current`=weight for the single cycle after edge n, then 0.
- **Saturated step.** If an update does not change the weight (e.g. +16 at 255), `update_w_flag` still pulses.
- **Back-to-back updates.** Updates on consecutive edges apply in order, one per cycle.

## Structure
- **Package `stdp_pkg`:**
  - default constants WINDOW, DELTA_MAX, W_MAX
  - timer width localparam: clog2(WINDOW)+1
  - enum `upd_t` {UPD_NONE, UPD_LTP, UPD_LTD}
  - function `stdp_delta(dt)`
- **Sub-module `spike_timer`.** Saturating since-last-spike counter with inputs clk, rst_n, spike and output count. Instantiated twice.
- **Top body.** The stage-1 trigger/delta logic, the stage-2 weight register with clamp, and the `syn_current` register.

## Test plan
- **LTP.** Reset, `learn_en`=1; pre at edge 10, post at edge 13 → dt=2, delta=16. After edge 14: `weight`=17, `ltp_flag`=1, `time_diff`=2, with a one-cycle `update_w_flag`.
- **LTD.** From weight 17: post at edge 30, pre at edge 36 → dt=5, delta=8. After edge 37: `weight`=9, `ltp_flag`=0.
- **Window edges.** pre→post gap giving dt=15 → delta 2. Gap giving `t_pre`=16 (saturated) → no update and no flag.
- **Saturation.** Weight 250, LTP delta 16 → 255 with flag pulse. Weight 1, LTD delta 16 → 0 with flag pulse.
- **Simultaneous spikes and freeze.** Pre and post high on the same edge → weight unchanged, no flag, both timers 0. With `learn_en`=0, a valid LTP pair → weight unchanged, but `syn_current` still equals weight on the pre spike.
- **Current and reset.** With weight 17, a pre spike at edge n → `syn_current`=17 for one cycle, then 0. Assert `rst_n` between the trigger edge and the apply edge → `weight`=W_INIT (1) and no `update_w_flag` after release.

Source files
------------

// File: rtl/stdp_pkg.sv
// Shared constants, update-kind enum and STDP step-size function for the plastic synapse.
package stdp_pkg;

  localparam int WINDOW    = 16;
  localparam int DELTA_MAX = 16;
  localparam int W_MAX     = 255;
  localparam int TIMER_W   = $clog2(WINDOW) + 1;

  typedef enum logic [1:0] {
    UPD_NONE = 2'd0,
    UPD_LTP  = 2'd1,
    UPD_LTD  = 2'd2
  } upd_t;

  // Step halves every quarter window; returns 0 once shifted past all bits.
  function automatic logic [7:0] stdp_delta(input int dt, input int window, input int delta_max);
    int quarter;
    int shamt;
    quarter = (window / 4 > 0) ? window / 4 : 1;
    shamt   = dt / quarter;
    if (shamt > 30) begin
      return 8'd0;
    end
    return 8'(delta_max >> shamt);
  endfunction

endpackage

// File: rtl/spike_timer.sv
// Cycles-since-last-spike counter, saturating at WINDOW (WINDOW means "no recent spike").
module spike_timer
  import stdp_pkg::*;
#(
  parameter int WINDOW = stdp_pkg::WINDOW,
  parameter int TW     = $clog2(WINDOW) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spike,
  output logic [TW-1:0] count
);

  localparam logic [TW-1:0] SAT = TW'(WINDOW);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (spike) begin
      count_d = '0;
    end else if (count_q != SAT) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= SAT;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse: spike timers, two-stage weight update pipeline and registered output current.
module stdp_synapse
  import stdp_pkg::*;
#(
  parameter int W_INIT    = 1,
  parameter int W_MAX     = stdp_pkg::W_MAX,
  parameter int WINDOW    = stdp_pkg::WINDOW,
  parameter int DELTA_MAX = stdp_pkg::DELTA_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_spike,
  input  logic       post_spike,
  input  logic       learn_en,
  output logic [7:0] weight,
  output logic [7:0] syn_current,
  output logic       update_w_flag,
  output logic       ltp_flag,
  output logic [4:0] time_diff
);

  localparam int            TW    = $clog2(WINDOW) + 1;
  localparam logic [TW-1:0] WIN   = TW'(WINDOW);
  localparam logic [8:0]    WMAX9 = 9'(W_MAX);

  logic [TW-1:0] t_pre;
  logic [TW-1:0] t_post;

  spike_timer #(.WINDOW(WINDOW), .TW(TW)) u_t_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (pre_spike),
    .count (t_pre)
  );

  spike_timer #(.WINDOW(WINDOW), .TW(TW)) u_t_post (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (post_spike),
    .count (t_post)
  );

  upd_t          upd;
  logic [TW-1:0] dt_sel;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_ltp_q,   s1_ltp_d;
  logic [7:0]    s1_delta_q, s1_delta_d;
  logic [TW-1:0] s1_dt_q,    s1_dt_d;

  // dt is the opposite timer before this edge; coincident spikes never trigger.
  always_comb begin
    upd    = UPD_NONE;
    dt_sel = t_pre;
    if (learn_en && post_spike && !pre_spike && (t_pre < WIN)) begin
      upd    = UPD_LTP;
      dt_sel = t_pre;
    end else if (learn_en && pre_spike && !post_spike && (t_post < WIN)) begin
      upd    = UPD_LTD;
      dt_sel = t_post;
    end
    s1_valid_d = (upd != UPD_NONE);
    s1_ltp_d   = (upd == UPD_LTP);
    s1_delta_d = stdp_delta(int'(dt_sel), WINDOW, DELTA_MAX);
    s1_dt_d    = dt_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ltp_q   <= 1'b0;
      s1_delta_q <= '0;
      s1_dt_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ltp_q   <= s1_ltp_d;
      s1_delta_q <= s1_delta_d;
      s1_dt_q    <= s1_dt_d;
    end
  end

  logic [7:0] weight_q,      weight_d;
  logic [7:0] syn_current_q, syn_current_d;
  logic       upd_flag_q,    upd_flag_d;
  logic       ltp_flag_q,    ltp_flag_d;
  logic [4:0] time_diff_q,   time_diff_d;
  logic [8:0] w_sum;
  logic [8:0] w_diff;

  // Nine-bit arithmetic so the carry/borrow tells us when to clamp.
  always_comb begin
    w_sum       = {1'b0, weight_q} + {1'b0, s1_delta_q};
    w_diff      = {1'b0, weight_q} - {1'b0, s1_delta_q};
    weight_d    = weight_q;
    ltp_flag_d  = ltp_flag_q;
    time_diff_d = time_diff_q;
    upd_flag_d  = s1_valid_q;
    if (s1_valid_q) begin
      ltp_flag_d  = s1_ltp_q;
      time_diff_d = 5'(s1_dt_q);
      if (s1_ltp_q) begin
        weight_d = (w_sum > WMAX9) ? WMAX9[7:0] : w_sum[7:0];
      end else begin
        weight_d = w_diff[8] ? 8'd0 : w_diff[7:0];
      end
    end
    syn_current_d = pre_spike ? weight_q : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q      <= 8'(W_INIT);
      syn_current_q <= '0;
      upd_flag_q    <= 1'b0;
      ltp_flag_q    <= 1'b0;
      time_diff_q   <= '0;
    end else begin
      weight_q      <= weight_d;
      syn_current_q <= syn_current_d;
      upd_flag_q    <= upd_flag_d;
      ltp_flag_q    <= ltp_flag_d;
      time_diff_q   <= time_diff_d;
    end
  end

  assign weight        = weight_q;
  assign syn_current   = syn_current_q;
  assign update_w_flag = upd_flag_q;
  assign ltp_flag      = ltp_flag_q;
  assign time_diff     = time_diff_q;

endmodule

// File: tb/tb_stdp_synapse.sv
// Directed bench for stdp_synapse with hand-computed weights, flags, dt and current.
module tb_stdp_synapse;

  logic       clk;
  logic       rst_n;
  logic       pre_spike;
  logic       post_spike;
  logic       learn_en;
  logic [7:0] weight;
  logic [7:0] syn_current;
  logic       update_w_flag;
  logic       ltp_flag;
  logic [4:0] time_diff;

  int errors = 0;
  int checks = 0;

  stdp_synapse dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pre_spike     (pre_spike),
    .post_spike    (post_spike),
    .learn_en      (learn_en),
    .weight        (weight),
    .syn_current   (syn_current),
    .update_w_flag (update_w_flag),
    .ltp_flag      (ltp_flag),
    .time_diff     (time_diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive spikes for one edge; outputs are sampled 1ns after that edge.
  task automatic step(input logic p, input logic q);
    pre_spike  = p;
    post_spike = q;
    @(posedge clk);
    #1;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pre_spike = 1'b0; post_spike = 1'b0; learn_en = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (weight !== 8'd1) begin errors++; $display("FAIL reset_weight got=%0d exp=1", weight); end
    checks++; if (syn_current !== 8'd0) begin errors++; $display("FAIL reset_cur got=%0d exp=0", syn_current); end
    checks++; if (update_w_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got=%b exp=0", update_w_flag); end
    checks++; if (ltp_flag !== 1'b0) begin errors++; $display("FAIL reset_ltp got=%b exp=0", ltp_flag); end
    checks++; if (time_diff !== 5'd0) begin errors++; $display("FAIL reset_dt got=%0d exp=0", time_diff); end
    checks++; if (dut.t_pre !== 5'd16 || dut.t_post !== 5'd16) begin errors++; $display("FAIL reset_timers got=%0d/%0d exp=16/16", dut.t_pre, dut.t_post); end
  endtask

  task automatic test_ltp;
    step(1'b1, 1'b0);
    checks++; if (syn_current !== 8'd1) begin errors++; $display("FAIL ltp_cur got=%0d exp=1", syn_current); end
    idle(2);
    step(1'b0, 1'b1);
    checks++; if (update_w_flag !== 1'b0) begin errors++; $display("FAIL ltp_early_flag got=%b exp=0", update_w_flag); end
    step(1'b0, 1'b0);
    checks++; if (weight !== 8'd17) begin errors++; $display("FAIL ltp_weight got=%0d exp=17", weight); end
    checks++; if (update_w_flag !== 1'b1) begin errors++; $display("FAIL ltp_flag_pulse got=%b exp=1", update_w_flag); end
    checks++; if (ltp_flag !== 1'b1) begin errors++; $display("FAIL ltp_kind got=%b exp=1", ltp_flag); end
    checks++; if (time_diff !== 5'd2) begin errors++; $display("FAIL ltp_dt got=%0d exp=2", time_diff); end
    step(1'b0, 1'b0);
    checks++; if (update_w_flag !== 1'b0 || weight !== 8'd17) begin errors++; $display("FAIL ltp_after got flag=%b w=%0d exp flag=0 w=17", update_w_flag, weight); end
  endtask

  task automatic test_ltd;
    idle(20);
    step(1'b0, 1'b1);
    idle(5);
    step(1'b1, 1'b0);
    checks++; if (syn_current !== 8'd17) begin errors++; $display("FAIL ltd_cur got=%0d exp=17", syn_current); end
    step(1'b0, 1'b0);
    checks++; if (weight !== 8'd9) begin errors++; $display("FAIL ltd_weight got=%0d exp=9", weight); end
    checks++; if (update_w_flag !== 1'b1 || ltp_flag !== 1'b0) begin errors++; $display("FAIL ltd_flags got flag=%b ltp=%b exp 1/0", update_w_flag, ltp_flag); end
    checks++; if (time_diff !== 5'd5) begin errors++; $display("FAIL ltd_dt got=%0d exp=5", time_diff); end
    checks++; if (syn_current !== 8'd0) begin errors++; $display("FAIL ltd_cur_drop got=%0d exp=0", syn_current); end
  endtask

  task automatic test_window_edges;
    idle(20);
    step(1'b1, 1'b0);
    idle(15);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++; if (weight !== 8'd11 || update_w_flag !== 1'b1) begin errors++; $display("FAIL win15_weight got w=%0d flag=%b exp w=11 flag=1", weight, update_w_flag); end
    checks++; if (time_diff !== 5'd15 || ltp_flag !== 1'b1) begin errors++; $display("FAIL win15_dt got dt=%0d ltp=%b exp 15/1", time_diff, ltp_flag); end
    idle(20);
    step(1'b1, 1'b0);
    idle(16);
    checks++; if (dut.t_pre !== 5'd16) begin errors++; $display("FAIL win16_timer got=%0d exp=16", dut.t_pre); end
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++; if (update_w_flag !== 1'b0 || weight !== 8'd11) begin errors++; $display("FAIL win16_noupd got flag=%b w=%0d exp 0/11", update_w_flag, weight); end
    step(1'b0, 1'b0);
    checks++; if (update_w_flag !== 1'b0) begin errors++; $display("FAIL win16_noupd2 got flag=%b exp 0", update_w_flag); end
  endtask

  task automatic test_back_to_back;
    idle(20);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    checks++; if (update_w_flag !== 1'b0) begin errors++; $display("FAIL b2b_first got flag=%b exp 0", update_w_flag); end
    step(1'b1, 1'b0);
    checks++; if (weight !== 8'd27 || update_w_flag !== 1'b1 || ltp_flag !== 1'b1) begin errors++; $display("FAIL b2b_ltp got w=%0d flag=%b ltp=%b exp 27/1/1", weight, update_w_flag, ltp_flag); end
    checks++; if (syn_current !== 8'd11) begin errors++; $display("FAIL b2b_cur got=%0d exp=11", syn_current); end
    step(1'b0, 1'b0);
    checks++; if (weight !== 8'd11 || update_w_flag !== 1'b1 || ltp_flag !== 1'b0 || time_diff !== 5'd0) begin errors++; $display("FAIL b2b_ltd got w=%0d flag=%b ltp=%b dt=%0d exp 11/1/0/0", weight, update_w_flag, ltp_flag, time_diff); end
    step(1'b0, 1'b0);
    checks++; if (update_w_flag !== 1'b0) begin errors++; $display("FAIL b2b_end got flag=%b exp 0", update_w_flag); end
  endtask

  task automatic test_simultaneous_freeze;
    idle(20);
    step(1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b1);
    checks++; if (dut.t_pre !== 5'd0 || dut.t_post !== 5'd0) begin errors++; $display("FAIL sim_timers got=%0d/%0d exp=0/0", dut.t_pre, dut.t_post); end
    step(1'b0, 1'b0);
    checks++; if (update_w_flag !== 1'b0 || weight !== 8'd11) begin errors++; $display("FAIL sim_noupd got flag=%b w=%0d exp 0/11", update_w_flag, weight); end
    idle(20);
    learn_en = 1'b0;
    step(1'b1, 1'b0);
    checks++; if (syn_current !== 8'd11) begin errors++; $display("FAIL frz_cur got=%0d exp=11", syn_current); end
    idle(2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++; if (update_w_flag !== 1'b0 || weight !== 8'd11) begin errors++; $display("FAIL frz_noupd got flag=%b w=%0d exp 0/11", update_w_flag, weight); end
    learn_en = 1'b1;
  endtask

  task automatic test_current;
    idle(20);
    step(1'b1, 1'b0);
    checks++; if (syn_current !== 8'd11) begin errors++; $display("FAIL cur_on got=%0d exp=11", syn_current); end
    step(1'b0, 1'b0);
    checks++; if (syn_current !== 8'd0) begin errors++; $display("FAIL cur_off got=%0d exp=0", syn_current); end
  endtask

  task automatic test_reset_mid;
    idle(20);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    checks++; if (weight !== 8'd1) begin errors++; $display("FAIL rmid_weight got=%0d exp=1", weight); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (update_w_flag !== 1'b0 || weight !== 8'd1) begin errors++; $display("FAIL rmid_noflag got flag=%b w=%0d exp 0/1", update_w_flag, weight); end
    step(1'b0, 1'b0);
    checks++; if (update_w_flag !== 1'b0) begin errors++; $display("FAIL rmid_noflag2 got flag=%b exp 0", update_w_flag); end
  endtask

  task automatic ltp_pair(input int gap, input logic [7:0] exp_w);
    step(1'b1, 1'b0);
    idle(gap);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    checks++; if (weight !== exp_w || update_w_flag !== 1'b1 || ltp_flag !== 1'b1 || time_diff !== 5'(gap)) begin
      errors++; $display("FAIL sat_ltp gap=%0d got w=%0d flag=%b ltp=%b dt=%0d exp w=%0d flag=1 ltp=1", gap, weight, update_w_flag, ltp_flag, time_diff, exp_w);
    end
    idle(17);
  endtask

  task automatic test_saturation;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++; if (weight !== 8'd0 || update_w_flag !== 1'b1 || ltp_flag !== 1'b0) begin errors++; $display("FAIL sat_floor got w=%0d flag=%b ltp=%b exp 0/1/0", weight, update_w_flag, ltp_flag); end
    idle(17);
    for (int k = 1; k <= 15; k++) ltp_pair(0, 8'(16 * k));
    ltp_pair(4, 8'd248);
    ltp_pair(12, 8'd250);
    ltp_pair(0, 8'd255);
    ltp_pair(0, 8'd255);
  endtask

  initial begin
    pre_spike = 1'b0; post_spike = 1'b0; learn_en = 1'b1; rst_n = 1'b0;
    test_reset();
    test_ltp();
    test_ltd();
    test_window_edges();
    test_back_to_back();
    test_simultaneous_freeze();
    test_current();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
